timer: RTL and testbench

Memory-mapped down-counting timer, a slave on the picorv32 native memory bus, alongside the RAM and UART.
- The top-level decoder gates mem_valid for this block with address region 0x6xxx_xxxx; the block itself only decodes mem_addr[4:2].
- Its irq output drives bit 7 of the core's irq vector, giving firmware a periodic tick source.

---
 rtl/timer_pkg.sv | 34 +++
 rtl/timer_defs.vh | 22 ++
 rtl/timer_prescaler.sv | 37 +++
 rtl/timer.sv | 146 ++++++++++++++
 tb/tb_timer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
//  timer_pkg
//  Shared types and helpers for the memory-mapped down-counting timer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    // Merge a bus write into an existing 32-bit word, one byte lane per strobe.
    function automatic logic [31:0] apply_wstrb(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  wstrb
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/timer_defs.vh
// ============================================================================
//  timer_defs.vh
//  Register byte offsets and bit positions shared by RTL and firmware headers.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`ifndef TIMER_DEFS_VH
`define TIMER_DEFS_VH

`define TIMER_CTRL              5'h00
`define TIMER_LOAD              5'h04
`define TIMER_VALUE             5'h08
`define TIMER_STATUS            5'h0C
`define TIMER_PRESC             5'h10

`define TIMER_CTRL_EN           0
`define TIMER_CTRL_AUTO_RELOAD  1
`define TIMER_CTRL_IRQ_EN       2
`define TIMER_STATUS_EXPIRED    0

`endif
`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
//  timer_prescaler
//  Free-running clock divider producing a one-cycle tick every PRESC+1 clocks.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module timer_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic [PRESC_WIDTH-1:0] presc,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] r_cnt;
    logic                   w_hit;

    assign w_hit = (r_cnt == presc);
    assign tick  = en && !clr && w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || clr || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer.sv
// ============================================================================
//  timer
//  Down-counting timer slave on the picorv32 native memory bus with IRQ.
//  Revision: 1.0
// ============================================================================
`include "timer_defs.vh"
`default_nettype none

module timer
    import timer_pkg::*;
#(
    parameter int          PRESC_WIDTH = 16,
    parameter logic [31:0] RESET_LOAD  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    logic                   r_ready;
    logic [31:0]            r_rdata;
    logic                   r_irq;
    ctrl_t                  r_ctrl;
    logic [31:0]            r_load;
    logic [31:0]            r_value;
    logic                   r_expired;
    logic [PRESC_WIDTH-1:0] r_presc;

    logic                   w_access;
    logic                   w_wr;
    logic [4:0]             w_off;
    logic                   w_wr_ctrl;
    logic                   w_wr_load;
    logic                   w_wr_value;
    logic                   w_wr_status;
    logic                   w_wr_presc;
    logic                   w_tick;
    logic                   w_expire;
    logic [31:0]            w_presc_ext;
    logic [31:0]            w_presc_new;
    logic [31:0]            w_rd_mux;
    logic                   w_unused_addr;

    // An access is accepted only when not already acknowledging, so a held
    // mem_valid never earns a second ready for the same request.
    assign w_access    = mem_valid && !r_ready;
    assign w_wr        = w_access && (mem_wstrb != 4'b0000);
    assign w_off       = {mem_addr[4:2], 2'b00};
    assign w_wr_ctrl   = w_wr && (w_off == `TIMER_CTRL);
    assign w_wr_load   = w_wr && (w_off == `TIMER_LOAD);
    assign w_wr_value  = w_wr && (w_off == `TIMER_VALUE);
    assign w_wr_status = w_wr && (w_off == `TIMER_STATUS);
    assign w_wr_presc  = w_wr && (w_off == `TIMER_PRESC);

    assign w_expire    = w_tick && (r_value == 32'h0);
    assign w_presc_ext = 32'(r_presc);
    assign w_presc_new = apply_wstrb(w_presc_ext, mem_wdata, mem_wstrb);

    assign w_unused_addr = &{1'b0, mem_addr[31:5], mem_addr[1:0]};

    timer_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_ctrl.en),
        .clr   (w_wr_value),
        .presc (r_presc),
        .tick  (w_tick)
    );

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_off)
            `TIMER_CTRL:   w_rd_mux = {29'h0, r_ctrl};
            `TIMER_LOAD:   w_rd_mux = r_load;
            `TIMER_VALUE:  w_rd_mux = r_value;
            `TIMER_STATUS: w_rd_mux = {31'h0, r_expired};
            `TIMER_PRESC:  w_rd_mux = w_presc_ext;
            default:       w_rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready   <= 1'b0;
            r_rdata   <= 32'h0;
            r_irq     <= 1'b0;
            r_ctrl    <= '0;
            r_load    <= RESET_LOAD;
            r_value   <= RESET_LOAD;
            r_expired <= 1'b0;
            r_presc   <= '0;
        end else begin
            r_ready <= w_access;
            r_rdata <= w_access ? w_rd_mux : 32'h0;
            r_irq   <= r_expired && r_ctrl.irq_en;

            if (w_tick) begin
                if (r_value != 32'h0) begin
                    r_value <= r_value - 32'd1;
                end else if (r_ctrl.auto_reload) begin
                    r_value <= r_load;
                end else begin
                    r_ctrl.en <= 1'b0;
                end
            end

            // Later assignments below take priority over the tick effects above.
            if (w_wr_status && mem_wstrb[0] && mem_wdata[`TIMER_STATUS_EXPIRED]) begin
                r_expired <= 1'b0;
            end
            if (w_expire) begin
                r_expired <= 1'b1;
            end

            if (w_wr_ctrl && mem_wstrb[0]) begin
                r_ctrl.en          <= mem_wdata[`TIMER_CTRL_EN];
                r_ctrl.auto_reload <= mem_wdata[`TIMER_CTRL_AUTO_RELOAD];
                r_ctrl.irq_en      <= mem_wdata[`TIMER_CTRL_IRQ_EN];
            end
            if (w_wr_load) begin
                r_load <= apply_wstrb(r_load, mem_wdata, mem_wstrb);
            end
            if (w_wr_value) begin
                r_value <= apply_wstrb(r_value, mem_wdata, mem_wstrb);
            end
            if (w_wr_presc) begin
                r_presc <= w_presc_new[PRESC_WIDTH-1:0];
            end
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign irq       = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_timer.sv
// ============================================================================
//  tb_timer
//  Directed self-checking testbench for the timer block.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_timer;

    localparam logic [31:0] RL       = 32'hCAFE_0005;
    localparam logic [31:0] A_CTRL   = 32'h6000_0000;
    localparam logic [31:0] A_LOAD   = 32'h6000_0004;
    localparam logic [31:0] A_VALUE  = 32'h6000_0008;
    localparam logic [31:0] A_STATUS = 32'h6000_000C;
    localparam logic [31:0] A_PRESC  = 32'h6000_0010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer #(
        .PRESC_WIDTH (16),
        .RESET_LOAD  (RL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One access, returns 1ns after the acknowledging edge (ready still high).
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = d;
        mem_wstrb = s;
        cyc(1);
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL bus_ready addr=%h got=%b want=1", a, mem_ready);
        end
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0000;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(a, d, 4'hF, dummy);
        cyc(1);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus(a, 32'h0, 4'h0, v);
        cyc(1);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] exp_v;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ready=%b rdata=%h irq=%b want 0/0/0",
                     mem_ready, mem_rdata, irq);
        end
        rst_n = 1'b1;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            bus(32'h6000_0000 + 32'(i * 4), 32'h0, 4'h0, v);
            exp_v = (i == 1 || i == 2) ? RL : 32'h0;
            checks++;
            if (v !== exp_v) begin
                errors++;
                $display("FAIL reset_read off=%0h got=%h want=%h", i * 4, v, exp_v);
            end
            cyc(1);
            checks++;
            if (mem_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_single off=%0h got=%b want=0", i * 4, mem_ready);
            end
        end
    endtask

    task automatic test_presc_mask;
        logic [31:0] v;
        wr(A_PRESC, 32'hFFFF_0001);
        rd(A_PRESC, v);
        checks++;
        if (v !== 32'h0000_0001) begin
            errors++;
            $display("FAIL presc_mask got=%h want=00000001", v);
        end
    endtask

    task automatic test_periodic_irq;
        logic [31:0] v;
        wr(A_LOAD, 32'd3);
        wr(A_PRESC, 32'd1);
        wr(A_VALUE, 32'd3);
        wr(A_STATUS, 32'd1);
        bus(A_CTRL, 32'h7, 4'hF, v);       // EN rises at E0
        cyc(8);                              // E8+1: EXPIRED just set
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_early got=%b want=0", irq);
        end
        bus(A_STATUS, 32'h0, 4'h0, v);      // E9+1
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL periodic_expired got=%h want=1", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL periodic_irq got=%b want=1", irq);
        end
        cyc(1);
        bus(A_STATUS, 32'h1, 4'hF, v);      // cleared at E11
        cyc(1);                              // E12+1
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%b want=0", irq);
        end
        cyc(4);                              // E16+1: second expiry set
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_second_early got=%b want=0", irq);
        end
        cyc(1);                              // E17+1
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_second got=%b want=1", irq);
        end
    endtask

    task automatic test_value_sequence;
        logic [31:0] v;
        logic [31:0] exp_seq [8];
        exp_seq = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0};
        for (int p = 1; p < 8; p++) begin
            wr(A_CTRL, 32'h0);
            wr(A_VALUE, 32'd3);
            bus(A_CTRL, 32'h7, 4'hF, v);
            cyc(p);
            bus(A_VALUE, 32'h0, 4'h0, v);
            checks++;
            if (v !== exp_seq[p]) begin
                errors++;
                $display("FAIL value_seq idx=%0d got=%0d want=%0d", p, v, exp_seq[p]);
            end
            cyc(1);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_LOAD, 32'd2);
        wr(A_VALUE, 32'd2);
        wr(A_PRESC, 32'd0);
        bus(A_CTRL, 32'h1, 4'hF, v);        // E0
        cyc(1);
        bus(A_STATUS, 32'h0, 4'h0, v);      // sampled before E2
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_early got=%h want=0", v);
        end
        cyc(1);
        bus(A_STATUS, 32'h0, 4'h0, v);      // sampled after E3
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL oneshot_expired got=%h want=1", v);
        end
        cyc(1);
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_ctrl got=%h want=0", v);
        end
        cyc(10);
        rd(A_VALUE, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL oneshot_value got=%h want=0", v);
        end
    endtask

    task automatic test_clear_race;
        logic [31:0] v;
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);
        wr(A_VALUE, 32'd2);
        bus(A_CTRL, 32'h5, 4'hF, v);        // E0, expiry at E3
        cyc(2);
        bus(A_STATUS, 32'h1, 4'hF, v);      // clear lands on E3
        cyc(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL race_irq got=%b want=1", irq);
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL race_set_wins got=%h want=1", v);
        end
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'h4) begin
            errors++;
            $display("FAIL race_ctrl got=%h want=4", v);
        end
        wr(A_STATUS, 32'h0);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL status_write0 got=%h want=1", v);
        end
        bus(A_STATUS, 32'h1, 4'hF, v);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_hold got=%b want=1", irq);
        end
        cyc(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_drop got=%b want=0", irq);
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL status_cleared got=%h want=0", v);
        end
    endtask

    task automatic test_byte_strobe;
        logic [31:0] v;
        wr(A_LOAD, 32'h0);
        bus(A_LOAD, 32'hAABB_CCDD, 4'b0101, v);
        cyc(1);
        rd(A_LOAD, v);
        checks++;
        if (v !== 32'h00BB_00DD) begin
            errors++;
            $display("FAIL byte_strobe got=%h want=00bb00dd", v);
        end
    endtask

    task automatic test_hold_valid;
        logic        exp_rdy;
        logic [31:0] exp_d;
        mem_valid = 1'b1;
        mem_addr  = A_CTRL;
        mem_wstrb = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            exp_rdy = (i % 2 == 0);
            exp_d   = exp_rdy ? 32'h4 : 32'h0;
            checks++;
            if (mem_ready !== exp_rdy || mem_rdata !== exp_d) begin
                errors++;
                $display("FAIL hold_valid cyc=%0d got ready=%b rdata=%h want ready=%b rdata=%h",
                         i, mem_ready, mem_rdata, exp_rdy, exp_d);
            end
        end
        mem_valid = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid_access;
        logic [31:0] v;
        wr(A_PRESC, 32'd5);
        mem_valid = 1'b1;
        mem_addr  = A_CTRL;
        mem_wstrb = 4'h0;
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_drop got ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
        end
        mem_valid = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        rd(A_CTRL, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_ctrl got=%h want=0", v);
        end
        rd(A_PRESC, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reset_presc got=%h want=0", v);
        end
        mem_valid = 1'b1;
        mem_addr  = A_LOAD;
        mem_wdata = 32'h55;
        mem_wstrb = 4'hF;
        #3 rst_n = 1'b0;
        cyc(1);
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        rst_n     = 1'b1;
        cyc(1);
        rd(A_LOAD, v);
        checks++;
        if (v !== RL) begin
            errors++;
            $display("FAIL abort_load got=%h want=%h", v, RL);
        end
        rd(A_VALUE, v);
        checks++;
        if (v !== RL) begin
            errors++;
            $display("FAIL abort_value got=%h want=%h", v, RL);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_wstrb = 4'h0;
        cyc(2);
        test_reset();
        test_presc_mask();
        test_periodic_irq();
        test_value_sequence();
        test_oneshot();
        test_clear_race();
        test_byte_strobe();
        test_hold_valid();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
